debug_probe_mux: RTL and testbench
==================================

Name: debug_probe_mux

Overview:
Parametrised debug display source for the FPGA top level, replacing fixed 8-way display selection. Routes N 32-bit probe channels (register-file read, instruction, ALU out, dmem wd, ...) and PC to the 8-digit hex display. Adds three modes: manual selection, timed auto-rotation, and breakpoint freeze with full-channel snapshot. Sits between the CPU debug/observation signals and display_controller, in the display clock domain.

Parameters:
NUM_CH, 8, number of probe channels (>=2)
WIDTH, 32, bits per probe channel; must be a multiple of 16
ROTATE_TICKS, 5000, clock cycles each slice is shown in auto mode (>=2)

Ports:
clock  in  1  display clock
reset  in  1  asynchronous, active-high reset
probes  in  NUM_CH*WIDTH  flattened channels; ch k = probes[k*WIDTH +: WIDTH]
pc  in  32  live program counter
mode  in  2  0=MANUAL, 1=AUTO, 2=FREEZE, 3=treated as MANUAL
sel_ch  in  $clog2(NUM_CH)  manual channel select
sel_slice  in  $clog2(WIDTH/16) (min 1)  manual 16-bit slice select; 0 = bits[15:0]
bp_addr  in  32  breakpoint PC
arm  in  1  single-cycle pulse: clear freeze, re-arm capture
bcds  out  32  {pc_shown[15:0], slice_shown[15:0]}; nibble 7 leftmost
frozen  out  1  snapshot held
cur_ch  out  $clog2(NUM_CH)  channel currently displayed
cur_slice  out  $clog2(WIDTH/16)  slice currently displayed

Behaviour:
- Reset: bcds=0, frozen=0, cur_ch=0, cur_slice=0, dwell counter=0, FSM=LIVE, snapshot regs=0.
- All outputs registered; 1-cycle latency from input change to bcds.
- Channel index >= NUM_CH (non-power-of-2 NUM_CH): slice_shown=0; cur_ch still reports index.
- MANUAL: cur_ch=sel_ch, cur_slice=sel_slice; source = live probes, live pc.
- AUTO: dwell counter counts 0..ROTATE_TICKS-1; on terminal count, cur_slice increments; wrap of slice increments cur_ch; wrap from (NUM_CH-1, last slice) goes to (0,0). Source = live.
- Entering AUTO from any other mode (mode changes to 1): counter, cur_ch, cur_slice cleared to 0 the same edge.
- FREEZE FSM (active only when mode=2; other modes force LIVE and frozen=0):
  LIVE -> ARMED on first cycle of mode=2.
  ARMED: display live with manual selection; pc==bp_addr -> capture all channels and pc into snapshot on that edge, go FROZEN.
  FROZEN: frozen=1, display snapshot with manual selection; live inputs ignored.
  arm pulse in ARMED or FROZEN -> ARMED, frozen=0 next cycle; arm has priority over simultaneous pc match (no capture that cycle).
  arm outside mode=2: ignored.
- Leaving mode=2 discards snapshot state (FSM->LIVE); snapshot registers keep contents but are unused until next capture.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package global_types additions: probe_mode_t enum {PROBE_MANUAL, PROBE_AUTO, PROBE_FREEZE}; freeze_state_t enum {FRZ_LIVE, FRZ_ARMED, FRZ_FROZEN}.
- One sub-module: probe_rotator (dwell counter + ch/slice wrap logic, with clear input), reused by any future multi-channel viewer.

Test Plan:
- Reset asserted mid-AUTO at ch3 -> next edge bcds=0, cur_ch=0, cur_slice=0, frozen=0 asynchronously.
- MANUAL, ch2=32'hDEADBEEF, pc=32'h00000040, sel_ch=2, sel_slice=1 -> one cycle later bcds=32'h0040DEAD.
- AUTO, ROTATE_TICKS=4, NUM_CH=3 -> (ch,slice) steps every 4 cycles: (0,0),(0,1),(1,0),(1,1),(2,0),(2,1),(0,0).
- FREEZE, bp_addr=32'h0000000C, ch0 live changes after pc hits 0x0C -> frozen=1, bcds holds 0x000C + captured ch0 slice; later ch0 changes have no effect.
- FROZEN, arm pulse same cycle pc==bp_addr -> no capture, ARMED, frozen=0; next match captures.
- NUM_CH=5, sel_ch=6 in MANUAL -> slice_shown=16'h0000, cur_ch=6.

Source files
------------

// File: rtl/debug_probe_mux_pkg.sv
// ---------------------------------------------------------------------------
// debug_probe_mux_pkg
// Shared types for the debug probe display path: display mode encoding,
// breakpoint-freeze FSM states, and small width helpers.
// ---------------------------------------------------------------------------
package debug_probe_mux_pkg;

  // Encoding matches the 2-bit mode input; code 3 decodes to MANUAL.
  typedef enum logic [1:0] {
    PROBE_MANUAL = 2'd0,
    PROBE_AUTO   = 2'd1,
    PROBE_FREEZE = 2'd2
  } probe_mode_t;

  typedef enum logic [1:0] {
    FRZ_LIVE   = 2'd0,
    FRZ_ARMED  = 2'd1,
    FRZ_FROZEN = 2'd2
  } freeze_state_t;

  // Width of one displayed slice (four hex digits).
  localparam int SLICE_W = 16;

  function automatic probe_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return PROBE_AUTO;
      2'd2:    return PROBE_FREEZE;
      default: return PROBE_MANUAL;
    endcase
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/probe_rotator.sv
// ---------------------------------------------------------------------------
// probe_rotator
// Dwell counter plus channel/slice walker for auto-rotating debug views.
// Each (channel, slice) pair is held for ROTATE_TICKS enabled cycles; slices
// advance first, a slice wrap advances the channel, and the last pair wraps
// to (0,0). A clear pulse zeroes everything on the same edge.
//
// Ports:
//   clock, reset     display clock, asynchronous active-high reset
//   clear            restart the walk at (0,0) with the counter at 0
//   enable           advance the dwell counter this cycle
//   ch_nxt           channel the walker holds after this edge
//   slice_nxt        slice the walker holds after this edge
// The next-state values are exported so a registered consumer shows the
// rotation position with no extra cycle of lag.
// ---------------------------------------------------------------------------
module probe_rotator
  import debug_probe_mux_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int NUM_SL       = 2,
  parameter int ROTATE_TICKS = 5000,
  localparam int CH_W        = idx_width(NUM_CH),
  localparam int SL_W        = idx_width(NUM_SL)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [CH_W-1:0] ch_nxt,
  output logic [SL_W-1:0] slice_nxt
);

  localparam int              CNT_W    = idx_width(ROTATE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROTATE_TICKS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [SL_W-1:0]  SL_LAST  = SL_W'(NUM_SL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [SL_W-1:0]  slice_q, slice_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and imply a latch.
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    slice_d = slice_q;
    if (clear) begin
      cnt_d   = '0;
      ch_d    = '0;
      slice_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (slice_q == SL_LAST) begin
          slice_d = '0;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
        end else begin
          slice_d = slice_q + SL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      slice_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      slice_q <= slice_d;
    end
  end

  assign ch_nxt    = ch_d;
  assign slice_nxt = slice_d;

endmodule

// File: rtl/debug_probe_mux.sv
// ---------------------------------------------------------------------------
// debug_probe_mux
// Selects one 16-bit slice of one probe channel, plus pc[15:0], for the
// 8-digit hex display. Modes: MANUAL (sel_ch/sel_slice), AUTO (timed
// rotation over every channel and slice), FREEZE (arm, then snapshot all
// channels and pc when pc hits bp_addr; display the snapshot until re-armed).
//
// Ports:
//   clock, reset   display clock, asynchronous active-high reset
//   probes         NUM_CH flattened channels, ch k = probes[k*WIDTH +: WIDTH]
//   pc             live program counter
//   mode           0 MANUAL, 1 AUTO, 2 FREEZE, 3 MANUAL
//   sel_ch         manual channel select (out-of-range shows a zero slice)
//   sel_slice      manual slice select, 0 = bits [15:0]
//   bp_addr        breakpoint pc for the freeze capture
//   arm            one-cycle pulse: drop snapshot, wait for next match
//   bcds           {pc_shown[15:0], slice_shown[15:0]}, registered
//   frozen         snapshot currently displayed
//   cur_ch         channel currently displayed
//   cur_slice      slice currently displayed
// ---------------------------------------------------------------------------
module debug_probe_mux
  import debug_probe_mux_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int WIDTH        = 32,
  parameter int ROTATE_TICKS = 5000,
  localparam int NUM_SL      = WIDTH / SLICE_W,
  localparam int CH_W        = idx_width(NUM_CH),
  localparam int SL_W        = idx_width(NUM_SL)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] probes,
  input  logic [31:0]             pc,
  input  logic [1:0]              mode,
  input  logic [CH_W-1:0]         sel_ch,
  input  logic [SL_W-1:0]         sel_slice,
  input  logic [31:0]             bp_addr,
  input  logic                    arm,
  output logic [31:0]             bcds,
  output logic                    frozen,
  output logic [CH_W-1:0]         cur_ch,
  output logic [SL_W-1:0]         cur_slice
);

  probe_mode_t   mode_dec, mode_q;
  freeze_state_t state_q, state_d;

  logic                    enter_auto;
  logic                    capture;
  logic                    use_snap;
  logic [CH_W-1:0]         rot_ch;
  logic [SL_W-1:0]         rot_slice;
  logic [CH_W-1:0]         ch_sel;
  logic [SL_W-1:0]         sl_sel;
  logic [NUM_CH*WIDTH-1:0] src_probes;
  logic [15:0]             src_pc;
  logic [15:0]             slice_val;

  // Only pc[15:0] is ever displayed, so only that part is snapshotted.
  logic [NUM_CH*WIDTH-1:0] snap_probes_q, snap_probes_d;
  logic [15:0]             snap_pc_q, snap_pc_d;

  logic [31:0]     bcds_q, bcds_d;
  logic            frozen_q, frozen_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic [SL_W-1:0] cur_slice_q, cur_slice_d;

  assign mode_dec   = decode_mode(mode);
  assign enter_auto = (mode_dec == PROBE_AUTO) && (mode_q != PROBE_AUTO);

  probe_rotator #(
    .NUM_CH       (NUM_CH),
    .NUM_SL       (NUM_SL),
    .ROTATE_TICKS (ROTATE_TICKS)
  ) u_rotator (
    .clock     (clock),
    .reset     (reset),
    .clear     (enter_auto),
    .enable    (mode_dec == PROBE_AUTO),
    .ch_nxt    (rot_ch),
    .slice_nxt (rot_slice)
  );

  // Freeze FSM next state. Outside FREEZE mode it is forced to LIVE; arm
  // beats a simultaneous pc match so a re-arm never captures that cycle.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (mode_dec != PROBE_FREEZE) begin
      state_d = FRZ_LIVE;
    end else begin
      case (state_q)
        FRZ_LIVE:   state_d = FRZ_ARMED;
        FRZ_ARMED: begin
          if (!arm && (pc == bp_addr)) begin
            state_d = FRZ_FROZEN;
            capture = 1'b1;
          end
        end
        FRZ_FROZEN: if (arm) state_d = FRZ_ARMED;
        default:    state_d = FRZ_LIVE;
      endcase
    end
  end

  // On the capture edge the snapshot equals the live inputs, so the live
  // path already shows the right value; the snapshot path is only needed
  // while the FSM stays FROZEN.
  assign use_snap = (state_q == FRZ_FROZEN) && (state_d == FRZ_FROZEN);

  always_comb begin
    snap_probes_d = capture ? probes    : snap_probes_q;
    snap_pc_d     = capture ? pc[15:0]  : snap_pc_q;
    src_probes    = use_snap ? snap_probes_q : probes;
    src_pc        = use_snap ? snap_pc_q     : pc[15:0];

    ch_sel = (mode_dec == PROBE_AUTO) ? rot_ch    : sel_ch;
    sl_sel = (mode_dec == PROBE_AUTO) ? rot_slice : sel_slice;

    // Constant-bounded search; an index with no matching channel or slice
    // falls through to zero.
    slice_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int s = 0; s < NUM_SL; s++) begin
        if ((ch_sel == CH_W'(k)) && (sl_sel == SL_W'(s))) begin
          slice_val = src_probes[k*WIDTH + s*SLICE_W +: SLICE_W];
        end
      end
    end

    bcds_d      = {src_pc, slice_val};
    frozen_d    = (state_d == FRZ_FROZEN);
    cur_ch_d    = ch_sel;
    cur_slice_d = sl_sel;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q        <= PROBE_MANUAL;
      state_q       <= FRZ_LIVE;
      // NOTE: the snapshot bank is reset too, so a display of it can never
      // show power-up garbage; it is small enough to live in flops.
      snap_probes_q <= '0;
      snap_pc_q     <= '0;
      bcds_q        <= '0;
      frozen_q      <= 1'b0;
      cur_ch_q      <= '0;
      cur_slice_q   <= '0;
    end else begin
      mode_q        <= mode_dec;
      state_q       <= state_d;
      snap_probes_q <= snap_probes_d;
      snap_pc_q     <= snap_pc_d;
      bcds_q        <= bcds_d;
      frozen_q      <= frozen_d;
      cur_ch_q      <= cur_ch_d;
      cur_slice_q   <= cur_slice_d;
    end
  end

  assign bcds      = bcds_q;
  assign frozen    = frozen_q;
  assign cur_ch    = cur_ch_q;
  assign cur_slice = cur_slice_q;

endmodule

// File: tb/tb_debug_probe_mux.sv
// ---------------------------------------------------------------------------
// tb_debug_probe_mux
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model that
// derives the displayed position from elapsed AUTO cycles and tracks the
// breakpoint snapshot directly.
// ---------------------------------------------------------------------------
module tb_debug_probe_mux;

  localparam int NUM_CH = 5;
  localparam int WIDTH  = 32;
  localparam int TICKS  = 4;
  localparam int NUM_SL = WIDTH / 16;
  localparam int CH_W   = 3;
  localparam int SL_W   = 1;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_CH*WIDTH-1:0] probes = '0;
  logic [31:0]             pc = '0;
  logic [1:0]              mode = '0;
  logic [CH_W-1:0]         sel_ch = '0;
  logic [SL_W-1:0]         sel_slice = '0;
  logic [31:0]             bp_addr = 32'h0000_000C;
  logic                    arm = 1'b0;
  logic [31:0]             bcds;
  logic                    frozen;
  logic [CH_W-1:0]         cur_ch;
  logic [SL_W-1:0]         cur_slice;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  debug_probe_mux #(
    .NUM_CH       (NUM_CH),
    .WIDTH        (WIDTH),
    .ROTATE_TICKS (TICKS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .probes    (probes),
    .pc        (pc),
    .mode      (mode),
    .sel_ch    (sel_ch),
    .sel_slice (sel_slice),
    .bp_addr   (bp_addr),
    .arm       (arm),
    .bcds      (bcds),
    .frozen    (frozen),
    .cur_ch    (cur_ch),
    .cur_slice (cur_slice)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                      m_n = 0;         // cycles since AUTO was entered
  bit                      m_prev_auto = 0;
  bit                      m_in_frz = 0;    // mode 2 seen on a previous edge
  bit                      m_held = 0;      // snapshot being displayed
  logic [NUM_CH*WIDTH-1:0] m_snap = '0;
  logic [15:0]             m_snap_pc = '0;
  logic [31:0]             e_bcds = '0;
  logic                    e_frozen = 1'b0;
  logic [CH_W-1:0]         e_ch = '0;
  logic [SL_W-1:0]         e_slice = '0;

  int                      md, ch, sl, pos, nx_n;
  bit                      nx_frz, nx_hld;
  logic [NUM_CH*WIDTH-1:0] nx_snap, src;
  logic [15:0]             nx_spc, pcs, val;

  always_comb begin
    md      = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
    nx_n    = m_n;
    ch      = int'(sel_ch);
    sl      = int'(sel_slice);
    pos     = 0;
    nx_frz  = m_in_frz;
    nx_hld  = m_held;
    nx_snap = m_snap;
    nx_spc  = m_snap_pc;
    src     = probes;
    pcs     = pc[15:0];
    val     = 16'h0;
    if (md == 1) begin
      nx_n = m_prev_auto ? m_n + 1 : 0;
      pos  = (nx_n / TICKS) % (NUM_CH * NUM_SL);
      ch   = pos / NUM_SL;
      sl   = pos % NUM_SL;
    end
    if (md != 2) begin
      nx_frz = 1'b0;
      nx_hld = 1'b0;
    end else if (!m_in_frz) begin
      nx_frz = 1'b1;
      nx_hld = 1'b0;
    end else if (arm) begin
      nx_hld = 1'b0;
    end else if (!m_held && (pc == bp_addr)) begin
      nx_hld  = 1'b1;
      nx_snap = probes;
      nx_spc  = pc[15:0];
    end
    if (nx_hld) begin
      src = nx_snap;
      pcs = nx_spc;
    end
    if (ch < NUM_CH) val = src[ch*WIDTH + sl*16 +: 16];
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_n         <= 0;
      m_prev_auto <= 1'b0;
      m_in_frz    <= 1'b0;
      m_held      <= 1'b0;
      m_snap      <= '0;
      m_snap_pc   <= '0;
      e_bcds      <= '0;
      e_frozen    <= 1'b0;
      e_ch        <= '0;
      e_slice     <= '0;
    end else begin
      m_n         <= nx_n;
      m_prev_auto <= (md == 1);
      m_in_frz    <= nx_frz;
      m_held      <= nx_hld;
      m_snap      <= nx_snap;
      m_snap_pc   <= nx_spc;
      e_bcds      <= {pcs, val};
      e_frozen    <= nx_hld;
      e_ch        <= CH_W'(ch);
      e_slice     <= SL_W'(sl);
    end
  end

  // Every-cycle comparison on the falling edge, away from the update edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("bcds", bcds, e_bcds);
      check("frozen", {31'b0, frozen}, {31'b0, e_frozen});
      check("cur_ch", {29'b0, cur_ch}, {29'b0, e_ch});
      check("cur_slice", {31'b0, cur_slice}, {31'b0, e_slice});
    end
  end

  // Advance one edge; afterwards outputs for the previous inputs are stable.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    bit found;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    check("rst_bcds", bcds, 32'h0);
    check("rst_frozen", {31'b0, frozen}, 32'h0);
    check("rst_ch", {29'b0, cur_ch}, 32'h0);
    check("rst_slice", {31'b0, cur_slice}, 32'h0);
    reset = 1'b0;

    // MANUAL selection of channel 2 upper slice
    probes[2*WIDTH +: 32] = 32'hDEADBEEF;
    pc = 32'h0000_0040;
    sel_ch = 3'd2;
    sel_slice = 1'b1;
    tick();
    check("manual_bcds", bcds, 32'h0040DEAD);
    check("manual_ch", {29'b0, cur_ch}, 32'd2);
    check("manual_model", e_bcds, 32'h0040DEAD);

    // Out-of-range channel shows a zero slice but reports the index
    sel_ch = 3'd6;
    tick();
    check("oor_bcds", bcds, 32'h00400000);
    check("oor_ch", {29'b0, cur_ch}, 32'd6);

    // AUTO: each (ch,slice) held for four cycles from the entry edge
    mode = 2'd1;
    tick();
    check("auto_entry", {28'b0, cur_ch, cur_slice}, {28'b0, 3'd0, 1'b0});
    repeat (3) tick();
    check("auto_hold", {28'b0, cur_ch, cur_slice}, {28'b0, 3'd0, 1'b0});
    tick();
    check("auto_step1", {28'b0, cur_ch, cur_slice}, {28'b0, 3'd0, 1'b1});
    check("auto_step1_bcds", bcds, 32'h0040_0000);
    repeat (4) tick();
    check("auto_step2", {28'b0, cur_ch, cur_slice}, {28'b0, 3'd1, 1'b0});

    // Asynchronous reset while AUTO is on channel 3
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (cur_ch == 3'd3) found = 1'b1;
      else tick();
    end
    check("auto_reach_ch3", {31'b0, found}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_bcds", bcds, 32'h0);
    check("async_rst_ch", {29'b0, cur_ch}, 32'h0);
    check("async_rst_slice", {31'b0, cur_slice}, 32'h0);
    check("async_rst_frozen", {31'b0, frozen}, 32'h0);
    tick();
    reset = 1'b0;
    mode = 2'd0;

    // FREEZE: first mode-2 cycle only arms even with pc on the breakpoint
    probes[0 +: 32] = 32'h1111_2222;
    sel_ch = 3'd0;
    sel_slice = 1'b0;
    pc = 32'h0000_000C;
    mode = 2'd2;
    tick();
    check("frz_first_cycle", {31'b0, frozen}, 32'h0);
    pc = 32'h0;
    tick();
    pc = 32'h0000_000C;
    tick();
    check("frz_capture", {31'b0, frozen}, 32'h1);
    check("frz_capture_bcds", bcds, 32'h000C2222);
    probes[0 +: 32] = 32'h3333_4444;
    pc = 32'h0000_0020;
    tick();
    check("frz_hold_bcds", bcds, 32'h000C2222);
    check("frz_hold_model", e_bcds, 32'h000C2222);
    arm = 1'b1;
    pc = 32'h0000_000C;
    tick();
    arm = 1'b0;
    check("arm_prio_frozen", {31'b0, frozen}, 32'h0);
    check("arm_prio_bcds", bcds, 32'h000C4444);
    tick();
    check("recapture_frozen", {31'b0, frozen}, 32'h1);
    check("recapture_bcds", bcds, 32'h000C4444);
    probes[0 +: 32] = 32'h5555_6666;
    pc = 32'h0000_0024;
    tick();
    check("recapture_hold", bcds, 32'h000C4444);
    mode = 2'd0;
    tick();
    check("leave_frz_frozen", {31'b0, frozen}, 32'h0);
    check("leave_frz_bcds", bcds, 32'h00246666);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 23) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        sel_ch    = 3'($urandom_range(0, 7));
        sel_slice = 1'($urandom_range(0, 1));
      end
      arm = ($urandom_range(0, 11) == 0);
      pc  = ($urandom_range(0, 4) == 0) ? bp_addr : $urandom;
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 2) == 0) probes[k*WIDTH +: 32] = $urandom;
      end
      if ($urandom_range(0, 199) == 0) bp_addr = {16'h0, 16'($urandom)};
      tick();
    end
    arm = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
